// File: rtl/mem_lsu.sv
// mem_lsu: RV32I load/store unit sitting between the core and a word-wide
// data memory with a combinational read port.
//
// Ports
//   clk, reset                  clock, async active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, req_funct3          store flag and RV32I width/sign code
//   req_addr, req_wdata, req_pc byte address, right-aligned store data, PC
//   resp_valid                  one-cycle completion pulse
//   resp_rdata, resp_err        extended load data / error flag (RESP only)
//   dm_we, dm_a, dm_wd          word write strobe, word address, write word
//   dm_pc                       latched PC for the store trace
//   dm_rd                       read word at dm_a
//
// state | meaning
// IDLE  | ready for a request
// READ  | sample dm_rd: load extraction or sub-word store merge
// WRITE | one-cycle dm_we pulse
// RESP  | one-cycle resp_valid pulse
module mem_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [XLEN-1:0] req_pc,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            dm_we,
  output logic [XLEN-1:0] dm_a,
  output logic [XLEN-1:0] dm_wd,
  output logic [XLEN-1:0] dm_pc,
  input  logic [XLEN-1:0] dm_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t          state_q;
  logic            we_q;
  logic            err_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] pc_q;
  // Holds store data on accept; READ overwrites it with either the load
  // result or the merged store word, so one register serves both paths.
  logic [XLEN-1:0] data_q;
  logic            err_d;

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                              input logic [2:0] f3,
                                              input logic [1:0] a);
    logic [XLEN-1:0] sh;
    sh = word >> {a, 3'b000};
    case (f3)
      3'd0:    extract = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'd1:    extract = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'd4:    extract = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'd5:    extract = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: extract = word;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] word,
                                            input logic [XLEN-1:0] wd,
                                            input logic [2:0] f3,
                                            input logic [1:0] a);
    logic [XLEN-1:0] mask;
    mask = (f3 == 3'd0) ? {{(XLEN-8){1'b0}}, 8'hFF} : {{(XLEN-16){1'b0}}, 16'hFFFF};
    // Halfwords are aligned here, so the byte shift also lands on addr[1].
    merge = (word & ~(mask << {a, 3'b000})) | ((wd & mask) << {a, 3'b000});
  endfunction

  always_comb begin
    err_d = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'd0:    err_d = 1'b0;
        3'd1:    err_d = req_addr[0];
        3'd2:    err_d = |req_addr[1:0];
        default: err_d = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'd0, 3'd4: err_d = 1'b0;
        3'd1, 3'd5: err_d = req_addr[0];
        3'd2:       err_d = |req_addr[1:0];
        default:    err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      pc_q    <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q   <= req_we;
            err_q  <= err_d;
            f3_q   <= req_funct3;
            addr_q <= req_addr;
            pc_q   <= req_pc;
            data_q <= req_wdata;
            if (err_d)                            state_q <= RESP;
            else if (req_we && req_funct3 == 3'd2) state_q <= WRITE;
            else                                  state_q <= READ;
          end
        end
        READ: begin
          data_q  <= we_q ? merge(dm_rd, data_q, f3_q, addr_q[1:0])
                          : extract(dm_rd, f3_q, addr_q[1:0]);
          state_q <= we_q ? WRITE : RESP;
        end
        WRITE:   state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // All handshake/strobe outputs decode the state register directly, so an
  // async reset removes them immediately and dm_we cannot glitch.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = (state_q == RESP && !err_q && !we_q) ? data_q : '0;
  assign dm_we      = (state_q == WRITE);
  assign dm_a       = {addr_q[XLEN-1:2], 2'b00};
  assign dm_wd      = data_q;
  assign dm_pc      = pc_q;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        resp_valid, resp_err, dm_we;
  logic [31:0] resp_rdata, dm_a, dm_wd, dm_pc, dm_rd;

  mem_lsu #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_pc(req_pc), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dm_we(dm_we), .dm_a(dm_a), .dm_wd(dm_wd),
    .dm_pc(dm_pc), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign dm_rd = mem[dm_a[9:2]];
  always @(posedge clk) if (dm_we) mem[dm_a[9:2]] <= dm_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int lat; int acc; } resp_t;
  typedef struct { logic [31:0] a; logic [31:0] wd; logic [31:0] pc; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  int checks = 0;
  int failures = 0;
  int prev_lat = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (resp_valid) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_latency", cyc - e.acc + 1, e.lat);
        chk("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
      end
    end else begin
      chk("idle_resp_zero", {resp_rdata[31:1], resp_rdata[0] | resp_err}, 32'd0);
    end
  end

  // Memory write monitor
  always @(negedge clk) begin
    if (dm_we) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_dm_we", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("dm_a", dm_a, w.a);
        chk("dm_wd", dm_wd, w.wd);
        chk("dm_pc", dm_pc, w.pc);
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc, input logic has_resp,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat,
                       input logic has_wr, input logic [31:0] wa, input logic [31:0] wd);
    int w;
    w = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_pc = pc;
    while (!req_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      return;
    end
    chk("ready_gap", w, prev_lat);
    if (has_resp) resp_q.push_back('{exp_rd, exp_err, lat, cyc + 1});
    if (has_wr) wr_q.push_back('{wa, wd, pc});
    prev_lat = lat;
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h11223344;  // 0x100
    mem[8'h42] = 32'h000000F0;  // 0x108
    mem[8'h43] = 32'h80017FFF;  // 0x10C
    mem[8'h44] = 32'h11223344;  // 0x110
    mem[8'h48] = 32'h55667788;  // 0x120
    req_valid = 0; req_we = 0; req_funct3 = 0;
    req_addr = 0; req_wdata = 0; req_pc = 0;
    reset = 1'b1;
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_strobes", {29'd0, resp_valid, resp_err, dm_we}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_dm_a", dm_a, 32'd0);
    chk("rst_dm_pc", dm_pc, 32'd0);
    @(posedge clk); #2 reset = 1'b0;

    // loads
    issue(0, 3'd0, 32'h103, 0, 32'h1000, 1, 32'h00000011, 0, 2, 0, 0, 0);
    issue(0, 3'd1, 32'h102, 0, 32'h1004, 1, 32'h00001122, 0, 2, 0, 0, 0);
    issue(0, 3'd0, 32'h108, 0, 32'h1008, 1, 32'hFFFFFFF0, 0, 2, 0, 0, 0);
    issue(0, 3'd4, 32'h108, 0, 32'h100C, 1, 32'h000000F0, 0, 2, 0, 0, 0);
    issue(0, 3'd5, 32'h100, 0, 32'h1010, 1, 32'h00003344, 0, 2, 0, 0, 0);
    issue(0, 3'd1, 32'h10C, 0, 32'h1014, 1, 32'h00007FFF, 0, 2, 0, 0, 0);
    issue(0, 3'd1, 32'h10E, 0, 32'h1018, 1, 32'hFFFF8001, 0, 2, 0, 0, 0);
    issue(0, 3'd5, 32'h10E, 0, 32'h101C, 1, 32'h00008001, 0, 2, 0, 0, 0);
    issue(0, 3'd2, 32'h100, 0, 32'h1020, 1, 32'h11223344, 0, 2, 0, 0, 0);
    // stores
    issue(1, 3'd0, 32'h101, 32'h123456AB, 32'h2000, 1, 0, 0, 3, 1, 32'h100, 32'h1122AB44);
    issue(1, 3'd1, 32'h112, 32'h0000BEEF, 32'h2004, 1, 0, 0, 3, 1, 32'h110, 32'hBEEF3344);
    issue(1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h2008, 1, 0, 0, 2, 1, 32'h104, 32'hDEADBEEF);
    issue(0, 3'd2, 32'h110, 0, 32'h200C, 1, 32'hBEEF3344, 0, 2, 0, 0, 0);
    issue(0, 3'd2, 32'h104, 0, 32'h2010, 1, 32'hDEADBEEF, 0, 2, 0, 0, 0);
    issue(0, 3'd2, 32'h100, 0, 32'h2014, 1, 32'h1122AB44, 0, 2, 0, 0, 0);
    // errors
    issue(0, 3'd2, 32'h102, 0, 32'h3000, 1, 0, 1, 1, 0, 0, 0);
    issue(1, 3'd1, 32'h101, 32'hFFFF, 32'h3004, 1, 0, 1, 1, 0, 0, 0);
    issue(0, 3'd3, 32'h100, 0, 32'h3008, 1, 0, 1, 1, 0, 0, 0);
    issue(1, 3'd4, 32'h100, 0, 32'h300C, 1, 0, 1, 1, 0, 0, 0);
    issue(0, 3'd5, 32'h101, 0, 32'h3010, 1, 0, 1, 1, 0, 0, 0);
    issue(0, 3'd6, 32'h100, 0, 32'h3014, 1, 0, 1, 1, 0, 0, 0);

    // SB aborted by reset during WRITE: the dm_we pulse is seen, no write lands
    issue(1, 3'd0, 32'h121, 32'h00, 32'h4000, 0, 0, 0, 3, 1, 32'h120, 32'h55660088);
    begin
      int n;
      n = 0;
      while (!dm_we && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("abort_reached_write", {31'd0, dm_we}, 32'd1);
    end
    #2 reset = 1'b1; req_valid = 1'b0;
    #1;
    chk("abort_dm_we_drop", {31'd0, dm_we}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("abort_mem_unchanged", mem[8'h48], 32'h55667788);
    @(posedge clk); #2 reset = 1'b0;
    prev_lat = 0;
    issue(0, 3'd2, 32'h120, 0, 32'h4004, 1, 32'h55667788, 0, 2, 0, 0, 0);
    issue(0, 3'd0, 32'h122, 0, 32'h4008, 1, 32'h00000066, 0, 2, 0, 0, 0);
    @(negedge clk) req_valid = 1'b0;

    begin
      int n;
      n = 0;
      while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    chk("resp_queue_drained", resp_q.size(), 32'd0);
    chk("wr_queue_drained", wr_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
